load_queue: RTL and testbench
=============================

# load_queue

In-order load queue for the memory backend. It sits beside the store queue on the shared mono memory dispatch port. It captures each load's rob_id and destination, receives the address from the AGU, and tracks how many older stores are still in the store queue. When no older store can alias, it issues a single outstanding word read to the data cache, then aligns and extends the returned data and broadcasts the result on its CDB port.

## Interface
- LDQ_DEPTH, 4: entries (power of 2); LDQ_IDX = log2(LDQ_DEPTH)
- STQ_DEPTH, 4: store-queue depth; STQ_IDX = log2(STQ_DEPTH)
- ROB_ID_W, 5: rob_id width
- PRF_IDX, 6: physical register index width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- backend_flush  in  1  discard all entries (synchronous, same effect as rst except drain tracking)
- ds_valid / ds_ready  in/out  1/1  dispatch handshake
- ds_fu_opcode  in  4  bit3=1 store (ignored), bit3=0 load; [2:0] funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- ds_rob_id / ds_pd  in  ROB_ID_W / PRF_IDX  tags of dispatched uop
- agu_valid, agu_rob_id, agu_addr  in  1, ROB_ID_W, 32  address writeback
- stq_tail  in  STQ_IDX+1  current store-queue occupancy
- stq_deq  in  1  store queue retired its head this cycle
- has_conflicting_store  in  LDQ_DEPTH  per-entry possible-alias flag
- ldq_addr  out  LDQ_DEPTH x 32  per-entry address
- ldq_tracker  out  LDQ_DEPTH x (STQ_IDX+1)  per-entry older-store count
- dmem_valid / dmem_ready  out/in  1/1  read request handshake
- dmem_addr / dmem_rmask  out  32 / 4  word-aligned address, byte mask
- dmem_resp_valid / dmem_rdata  in  1 / 32  read response
- cdb_valid, cdb_rob_id, cdb_pd, cdb_rd_value  out  1, ROB_ID_W, PRF_IDX, 32  result broadcast

## Operation
- Circular FIFO: wr_ptr/rd_ptr are LDQ_IDX+1 bits wide, with a wrap flag in the MSB.
  - full = same index, opposite flag; empty = pointers equal.
  - ds_ready = ~full. There is no bypass when a dequeue and an enqueue happen in the same cycle.
- Enqueue when ds_valid & ds_ready & ~ds_fu_opcode[3]. The entry is written as follows:
  - valid=1, addr_valid=0
  - rob_id, pd and funct3 from dispatch
  - tracker = stq_tail − stq_deq
- AGU write: if agu_valid, every valid entry whose rob_id equals agu_rob_id gets addr and addr_valid=1.
- Tracker update: on stq_deq, every valid entry with tracker≠0 decrements by 1. A decrement and the enqueue write in the same cycle apply to different entries.
- Conflict: entry i is blocked iff tracker_i≠0 && has_conflicting_store[i]. When tracker_i==0 the input is ignored.
- FSM states:
  - IDLE: dmem_valid = head valid & head addr_valid & ~blocked(head). On dmem_valid & dmem_ready → WAIT.
  - WAIT: on dmem_resp_valid, cdb_valid=1 and the head is dequeued → IDLE.
  - DRAIN: entered when backend_flush is asserted in WAIT, or in IDLE while a request is accepted. The next dmem_resp_valid is dropped → IDLE. No issue while in DRAIN; enqueue is allowed.
- Request fields:
  - dmem_addr = {head.addr[31:2], 2'b00}
  - dmem_rmask = 0001 (b), 0011 (h) or 1111 (w), shifted left by addr[1:0]
- Response data:
  - shift dmem_rdata right by 8×addr[1:0]
  - sign-extend for lb/lh; zero-extend for lbu/lhu; lw passes through
- Misaligned halfword/word accesses are unsupported (undefined result).
- CDB fields: cdb_rob_id and cdb_pd come from the head entry.
- Invalid entries drive ldq_tracker=0 and their stale ldq_addr.

## Timing
- Reset/flush: pointers=0, all valid=0, state=IDLE. rst also clears DRAIN; flush takes WAIT→DRAIN.
- Reset values: ds_ready=1, dmem_valid=0, cdb_valid=0, ldq_tracker all 0, ldq_addr 0 after rst.
- dmem_valid and its fields are combinational from registered state plus has_conflicting_store.
- cdb outputs are combinational from dmem_resp_valid in WAIT. Dequeue happens at that edge.
- Earliest request: the cycle after the AGU write. Earliest CDB: the cycle after request acceptance if dmem responds in one cycle.
- Only one load is outstanding at a time. dmem_valid is held, with stable fields, until dmem_ready.
- Wrap: pointers increment mod 2^(LDQ_IDX+1); entry index = low LDQ_IDX bits.
- Simultaneous flush and dmem_resp_valid in WAIT: the response is consumed (cdb_valid=0 because of the flush) and the next state is IDLE, not DRAIN.
- Simultaneous enqueue and dequeue when full: enqueue refused.

## Test plan
- Reset → ds_ready=1, dmem_valid=0, cdb_valid=0, ldq_tracker all 0.
- Load lbu at rob_id 3, pd 7, stq_tail=0; AGU addr 0x1003 → dmem_addr=0x1000, rmask=1000; rdata 0x80xxxxxx → cdb rob_id 3, pd 7, value 0x00000080. Repeat as lb → 0xFFFFFF80.
- stq_tail=2 at enqueue, has_conflicting_store=1 → no dmem_valid. Two stq_deq pulses → tracker 2→1→0, then dmem_valid=1 in the next cycle.
- Fill 4 loads → ds_ready=0. Drain all, refill 4 → correct wrap order of cdb_rob_id.
- Issue a load, hold dmem_resp_valid low, assert backend_flush → DRAIN. Enqueue a new load with addr ready; no request until the stale response arrives (dropped, cdb_valid=0), then the new request issues.
- stq_deq in the same cycle as enqueue with stq_tail=1 → captured tracker=0, and the load issues despite has_conflicting_store=1.

Source files
------------

// File: rtl/load_queue_if.sv
// Data-cache read port of the load queue: one request channel and one response channel.
interface load_queue_if;
  logic        dmem_valid;
  logic        dmem_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_valid, dmem_addr, dmem_rmask,
    input  dmem_ready, dmem_resp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_valid, dmem_addr, dmem_rmask,
    output dmem_ready, dmem_resp_valid, dmem_rdata
  );
endinterface

// File: rtl/load_queue.sv
// In-order load queue: waits for older stores to drain, issues one outstanding word read,
// then aligns/extends the returned data and broadcasts it on the CDB.
module load_queue #(
  parameter  int LDQ_DEPTH = 4,
  parameter  int STQ_DEPTH = 4,
  parameter  int ROB_ID_W  = 5,
  parameter  int PRF_IDX   = 6,
  localparam int LDQ_IDX   = $clog2(LDQ_DEPTH),
  localparam int STQ_IDX   = $clog2(STQ_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                backend_flush_i,
  input  logic                                ds_valid_i,
  output logic                                ds_ready_o,
  input  logic [3:0]                          ds_fu_opcode_i,
  input  logic [ROB_ID_W-1:0]                 ds_rob_id_i,
  input  logic [PRF_IDX-1:0]                  ds_pd_i,
  input  logic                                agu_valid_i,
  input  logic [ROB_ID_W-1:0]                 agu_rob_id_i,
  input  logic [31:0]                         agu_addr_i,
  input  logic [STQ_IDX:0]                    stq_tail_i,
  input  logic                                stq_deq_i,
  input  logic [LDQ_DEPTH-1:0]                has_conflicting_store_i,
  output logic [LDQ_DEPTH-1:0][31:0]          ldq_addr_o,
  output logic [LDQ_DEPTH-1:0][STQ_IDX:0]     ldq_tracker_o,
  load_queue_if.master                        dmem,
  output logic                                cdb_valid_o,
  output logic [ROB_ID_W-1:0]                 cdb_rob_id_o,
  output logic [PRF_IDX-1:0]                  cdb_pd_o,
  output logic [31:0]                         cdb_rd_value_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [LDQ_IDX:0] PTR_ONE = 1;
  localparam logic [STQ_IDX:0] TRK_ONE = 1;

  logic [LDQ_IDX:0]                  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LDQ_DEPTH-1:0]              valid_q, valid_d, addrValid_q, addrValid_d;
  logic [LDQ_DEPTH-1:0][31:0]        addr_q, addr_d;
  logic [LDQ_DEPTH-1:0][ROB_ID_W-1:0] robId_q, robId_d;
  logic [LDQ_DEPTH-1:0][PRF_IDX-1:0] pd_q, pd_d;
  logic [LDQ_DEPTH-1:0][2:0]         funct3_q, funct3_d;
  logic [LDQ_DEPTH-1:0][STQ_IDX:0]   tracker_q, tracker_d;
  logic [1:0]                        state_q, state_d;

  logic [LDQ_IDX-1:0] wrIdx, headIdx;
  logic               full, enq, deq, headBlocked, accept;
  logic [3:0]         baseMask;
  logic [31:0]        shifted;
  logic [31:0]        headAddr;
  logic [2:0]         headFunct3;

  assign wrIdx      = wrPtr_q[LDQ_IDX-1:0];
  assign headIdx    = rdPtr_q[LDQ_IDX-1:0];
  assign headAddr   = addr_q[headIdx];
  assign headFunct3 = funct3_q[headIdx];
  assign full       = (wrPtr_q[LDQ_IDX] != rdPtr_q[LDQ_IDX]) && (wrIdx == headIdx);
  assign ds_ready_o = ~full;
  assign enq        = ds_valid_i & ~full & ~ds_fu_opcode_i[3];

  // A non-zero tracker means some older store is still queued; only then does aliasing matter.
  assign headBlocked = (tracker_q[headIdx] != '0) && has_conflicting_store_i[headIdx];

  assign dmem.dmem_valid = (state_q == ST_IDLE) && valid_q[headIdx] && addrValid_q[headIdx] && !headBlocked;
  assign dmem.dmem_addr  = {headAddr[31:2], 2'b00};
  assign accept          = dmem.dmem_valid && dmem.dmem_ready;

  always_comb begin
    case (headFunct3[1:0])
      2'b00:   baseMask = 4'b0001;
      2'b01:   baseMask = 4'b0011;
      default: baseMask = 4'b1111;
    endcase
  end
  assign dmem.dmem_rmask = baseMask << headAddr[1:0];

  assign deq            = (state_q == ST_WAIT) && dmem.dmem_resp_valid && !backend_flush_i;
  assign cdb_valid_o    = deq;
  assign cdb_rob_id_o   = robId_q[headIdx];
  assign cdb_pd_o       = pd_q[headIdx];
  assign shifted        = dmem.dmem_rdata >> {headAddr[1:0], 3'b000};

  always_comb begin
    case (headFunct3)
      3'b000:  cdb_rd_value_o = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  cdb_rd_value_o = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  cdb_rd_value_o = {24'h0, shifted[7:0]};
      3'b101:  cdb_rd_value_o = {16'h0, shifted[15:0]};
      default: cdb_rd_value_o = shifted;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      ldq_addr_o[i]    = addr_q[i];
      ldq_tracker_o[i] = valid_q[i] ? tracker_q[i] : '0;
    end
  end

  // A flush with a read in flight must swallow that read's response before issuing again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = backend_flush_i ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (dmem.dmem_resp_valid)  state_d = ST_IDLE;
        else if (backend_flush_i)  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (dmem.dmem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    valid_d     = valid_q;
    addrValid_d = addrValid_q;
    addr_d      = addr_q;
    robId_d     = robId_q;
    pd_d        = pd_q;
    funct3_d    = funct3_q;
    tracker_d   = tracker_q;

    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (valid_q[i] && agu_valid_i && (robId_q[i] == agu_rob_id_i)) begin
        addr_d[i]      = agu_addr_i;
        addrValid_d[i] = 1'b1;
      end
      if (valid_q[i] && stq_deq_i && (tracker_q[i] != '0))
        tracker_d[i] = tracker_q[i] - TRK_ONE;
    end

    if (deq) begin
      valid_d[headIdx] = 1'b0;
      rdPtr_d          = rdPtr_q + PTR_ONE;
    end

    // The enqueue slot is never valid, so it cannot collide with the per-entry updates above.
    if (enq) begin
      valid_d[wrIdx]     = 1'b1;
      addrValid_d[wrIdx] = 1'b0;
      robId_d[wrIdx]     = ds_rob_id_i;
      pd_d[wrIdx]        = ds_pd_i;
      funct3_d[wrIdx]    = ds_fu_opcode_i[2:0];
      tracker_d[wrIdx]   = stq_tail_i - {{STQ_IDX{1'b0}}, stq_deq_i};
      wrPtr_d            = wrPtr_q + PTR_ONE;
    end

    if (backend_flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      valid_q     <= '0;
      addrValid_q <= '0;
      addr_q      <= '0;
      robId_q     <= '0;
      pd_q        <= '0;
      funct3_q    <= '0;
      tracker_q   <= '0;
      state_q     <= ST_IDLE;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      valid_q     <= valid_d;
      addrValid_q <= addrValid_d;
      addr_q      <= addr_d;
      robId_q     <= robId_d;
      pd_q        <= pd_d;
      funct3_q    <= funct3_d;
      tracker_q   <= tracker_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_load_queue.sv
// Randomized bench for load_queue: a driver plays dispatch, AGU, store queue and data cache;
// a negedge monitor keeps an in-order list of outstanding loads and checks every DUT output.
module tb_load_queue;
  localparam int LDQ_DEPTH = 4;
  localparam int STQ_DEPTH = 4;
  localparam int ROB_ID_W  = 5;
  localparam int PRF_IDX   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                        backendFlush, dsValid, dsReady, aguValid, stqDeq;
  logic [3:0]                  dsOpcode;
  logic [ROB_ID_W-1:0]         dsRobId, aguRobId;
  logic [PRF_IDX-1:0]          dsPd;
  logic [31:0]                 aguAddr;
  logic [2:0]                  stqTail;
  logic [LDQ_DEPTH-1:0]        hasConflict;
  logic [LDQ_DEPTH-1:0][31:0]  ldqAddr;
  logic [LDQ_DEPTH-1:0][2:0]   ldqTracker;
  logic                        cdbValid;
  logic [ROB_ID_W-1:0]         cdbRobId;
  logic [PRF_IDX-1:0]          cdbPd;
  logic [31:0]                 cdbValue;

  load_queue_if dmemIf();

  load_queue #(.LDQ_DEPTH(LDQ_DEPTH), .STQ_DEPTH(STQ_DEPTH), .ROB_ID_W(ROB_ID_W), .PRF_IDX(PRF_IDX)) dut (
    .clk(clk), .rst(rst), .backend_flush_i(backendFlush),
    .ds_valid_i(dsValid), .ds_ready_o(dsReady), .ds_fu_opcode_i(dsOpcode),
    .ds_rob_id_i(dsRobId), .ds_pd_i(dsPd),
    .agu_valid_i(aguValid), .agu_rob_id_i(aguRobId), .agu_addr_i(aguAddr),
    .stq_tail_i(stqTail), .stq_deq_i(stqDeq), .has_conflicting_store_i(hasConflict),
    .ldq_addr_o(ldqAddr), .ldq_tracker_o(ldqTracker), .dmem(dmemIf),
    .cdb_valid_o(cdbValid), .cdb_rob_id_o(cdbRobId), .cdb_pd_o(cdbPd), .cdb_rd_value_o(cdbValue)
  );

  typedef struct {
    logic [ROB_ID_W-1:0] rob;
    logic [PRF_IDX-1:0]  pd;
    logic [2:0]          f3;
    logic [31:0]         addr;
    bit                  addrOk;
    int                  trk;
  } load_t;

  typedef struct {
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         addr;
  } agu_t;

  load_t mq[$];
  agu_t  aguQ[$];
  int    headSlot, checks, errors, stqCount, memDelay;
  int    readyPct, dispPct, flushPer;
  bit    waitM, drainM, monOn, memOut, stopDisp;
  logic [31:0] memAddr;
  logic [ROB_ID_W-1:0] robCnt;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] loadResult(logic [2:0] f3, logic [31:0] a);
    logic [31:0] w;
    w = memWord({a[31:2], 2'b00}) >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] maskFor(logic [2:0] f3, logic [31:0] a);
    int bytes;
    bytes = 1 << f3[1:0];
    return 4'(((1 << bytes) - 1) << a[1:0]);
  endfunction

  function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Checks the current cycle's outputs, then advances the model by what the next edge will do.
  task automatic checkOutput();
    int    n, k;
    bit    expDv, expCdb, accept, resp;
    load_t e;
    n    = mq.size();
    resp = dmemIf.dmem_resp_valid;
    compare("ds_ready", 32'(dsReady), 32'(n < LDQ_DEPTH));
    for (int s = 0; s < LDQ_DEPTH; s++) begin
      k = (s - headSlot + LDQ_DEPTH) % LDQ_DEPTH;
      if (k < n) begin
        compare("tracker", 32'(ldqTracker[s]), 32'(mq[k].trk));
        if (mq[k].addrOk) compare("ldq_addr", ldqAddr[s], mq[k].addr);
      end else begin
        compare("tracker_empty", 32'(ldqTracker[s]), 32'd0);
      end
    end
    expDv = 1'b0;
    if (!waitM && !drainM && n > 0)
      expDv = mq[0].addrOk && !(mq[0].trk != 0 && hasConflict[headSlot]);
    compare("dmem_valid", 32'(dmemIf.dmem_valid), 32'(expDv));
    if (expDv && dmemIf.dmem_valid) begin
      compare("dmem_addr", dmemIf.dmem_addr, {mq[0].addr[31:2], 2'b00});
      compare("dmem_rmask", 32'(dmemIf.dmem_rmask), 32'(maskFor(mq[0].f3, mq[0].addr)));
    end
    expCdb = waitM && resp && !backendFlush;
    compare("cdb_valid", 32'(cdbValid), 32'(expCdb));
    if (expCdb && cdbValid) begin
      compare("cdb_rob_id", 32'(cdbRobId), 32'(mq[0].rob));
      compare("cdb_pd", 32'(cdbPd), 32'(mq[0].pd));
      compare("cdb_value", cdbValue, loadResult(mq[0].f3, mq[0].addr));
    end
    accept = expDv && dmemIf.dmem_ready;

    if (backendFlush) begin
      drainM   = (waitM && !resp) || accept || (drainM && !resp);
      waitM    = 1'b0;
      headSlot = 0;
      mq.delete();
    end else begin
      for (int j = 0; j < mq.size(); j++) begin
        e = mq[j];
        if (aguValid && e.rob == aguRobId) begin
          e.addr   = aguAddr;
          e.addrOk = 1'b1;
        end
        if (stqDeq && e.trk > 0) e.trk--;
        mq[j] = e;
      end
      if (expCdb) begin
        void'(mq.pop_front());
        headSlot = (headSlot + 1) % LDQ_DEPTH;
        waitM    = 1'b0;
      end
      if (drainM && resp) drainM = 1'b0;
      if (accept) waitM = 1'b1;
      if (dsValid && !dsOpcode[3] && n < LDQ_DEPTH) begin
        e.rob    = dsRobId;
        e.pd     = dsPd;
        e.f3     = dsOpcode[2:0];
        e.addr   = '0;
        e.addrOk = 1'b0;
        e.trk    = int'(stqTail) - int'(stqDeq);
        mq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) if (monOn) checkOutput();

  // One cycle of stimulus: memory, store queue, conflicts, AGU and dispatch.
  task automatic applyStimulus();
    logic [2:0]  f3;
    logic [31:0] a;
    bit          isStore;
    int          idx;
    agu_t        ag;
    @(posedge clk);
    #1;
    dmemIf.dmem_resp_valid = 1'b0;
    if (memOut) begin
      if (memDelay == 0) begin
        dmemIf.dmem_resp_valid = 1'b1;
        dmemIf.dmem_rdata      = memWord(memAddr);
        memOut                 = 1'b0;
      end else memDelay--;
    end
    dmemIf.dmem_ready = ($urandom_range(99) < readyPct);
    backendFlush = (flushPer > 0) && ($urandom_range(flushPer - 1) == 0);
    if (backendFlush) aguQ.delete();
    stqTail = 3'(stqCount);
    stqDeq  = (stqCount > 0) && ($urandom_range(1) == 1);
    stqCount = stqCount - int'(stqDeq);
    if (!stopDisp && stqCount < STQ_DEPTH && $urandom_range(2) == 0) stqCount++;
    hasConflict = 4'($urandom);
    aguValid = 1'b0;
    if (aguQ.size() > 0 && $urandom_range(1) == 1) begin
      idx      = $urandom_range(aguQ.size() - 1);
      aguValid = 1'b1;
      aguRobId = aguQ[idx].rob;
      aguAddr  = aguQ[idx].addr;
      aguQ.delete(idx);
    end
    dsValid = 1'b0;
    if (!stopDisp && !backendFlush && $urandom_range(99) < dispPct) begin
      isStore = ($urandom_range(4) == 0);
      case ($urandom_range(4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      dsValid  = 1'b1;
      dsOpcode = {isStore, f3};
      dsRobId  = robCnt;
      dsPd     = PRF_IDX'($urandom);
      if (dsReady && !isStore) begin
        ag.rob  = robCnt;
        ag.addr = a;
        aguQ.push_back(ag);
        robCnt++;
      end
    end
    #2;
    if (dmemIf.dmem_valid && dmemIf.dmem_ready) begin
      memOut   = 1'b1;
      memAddr  = dmemIf.dmem_addr;
      memDelay = $urandom_range(2);
    end
  endtask

  initial begin
    int budget;
    checks = 0; errors = 0; headSlot = 0; stqCount = 0; robCnt = '0;
    waitM = 0; drainM = 0; monOn = 0; memOut = 0; stopDisp = 0; memDelay = 0;
    rst = 1'b1; backendFlush = 0; dsValid = 0; dsOpcode = '0; dsRobId = '0; dsPd = '0;
    aguValid = 0; aguRobId = '0; aguAddr = '0; stqTail = '0; stqDeq = 0; hasConflict = '0;
    dmemIf.dmem_ready = 0; dmemIf.dmem_resp_valid = 0; dmemIf.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compare("reset_ds_ready", 32'(dsReady), 32'd1);
    compare("reset_dmem_valid", 32'(dmemIf.dmem_valid), 32'd0);
    compare("reset_cdb_valid", 32'(cdbValid), 32'd0);
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      compare("reset_tracker", 32'(ldqTracker[i]), 32'd0);
      compare("reset_addr", ldqAddr[i], 32'd0);
    end
    #1 monOn = 1'b1;

    readyPct = 70; dispPct = 60; flushPer = 0;
    repeat (800) applyStimulus();
    readyPct = 15; dispPct = 90;
    repeat (600) applyStimulus();
    readyPct = 60; dispPct = 70; flushPer = 25;
    repeat (1000) applyStimulus();

    stopDisp = 1; flushPer = 0; readyPct = 80;
    budget = 0;
    while ((mq.size() != 0 || memOut) && budget < 400) begin
      applyStimulus();
      budget++;
    end
    @(negedge clk);
    #1;
    compare("drain_complete", 32'(mq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
